// File: rtl/uart_tx_sequencer.sv
// Configures a 16750-style UART over its parallel bus, then feeds it one byte
// at a time, polling LSR.THRE before each THR write.
module uart_tx_sequencer #(
  parameter logic [15:0] DIVISOR = 16'h0011,
  parameter logic [7:0]  LCR_CFG = 8'h03,
  parameter logic [7:0]  FCR_CFG = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        uart_cs,
  output logic        uart_wr,
  output logic        uart_rd,
  output logic [2:0]  uart_addr,
  output logic [7:0]  uart_din,
  input  logic [7:0]  uart_dout,
  output logic        cfg_done,
  output logic [15:0] tx_count
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_DLAB  = 4'd1;
  localparam logic [3:0] S_CFG_DLL   = 4'd2;
  localparam logic [3:0] S_CFG_DLM   = 4'd3;
  localparam logic [3:0] S_CFG_LCR   = 4'd4;
  localparam logic [3:0] S_CFG_FCR   = 4'd5;
  localparam logic [3:0] S_CFG_IER   = 4'd6;
  localparam logic [3:0] S_WAIT_DATA = 4'd7;
  localparam logic [3:0] S_POLL_LSR  = 4'd8;
  localparam logic [3:0] S_WRITE_THR = 4'd9;

  localparam logic [2:0] A_LSR = 3'd5;

  logic [3:0]  r_state;
  logic [1:0]  r_ph;
  logic [7:0]  r_hold;
  logic [7:0]  r_lsr;
  logic        r_tx_ready;
  logic        r_cs;
  logic        r_wr;
  logic        r_rd;
  logic [2:0]  r_addr;
  logic [7:0]  r_din;
  logic        r_cfg_done;
  logic [15:0] r_tx_count;

  logic [2:0]  w_addr;
  logic [7:0]  w_din;
  logic [3:0]  w_next;

  // Target register, data and successor for every write-type state
  always_comb begin
    w_addr = 3'd0;
    w_din  = 8'h00;
    w_next = S_IDLE;
    case (r_state)
      S_CFG_DLAB:  begin w_addr = 3'd3; w_din = LCR_CFG | 8'h80; w_next = S_CFG_DLL;   end
      S_CFG_DLL:   begin w_addr = 3'd0; w_din = DIVISOR[7:0];    w_next = S_CFG_DLM;   end
      S_CFG_DLM:   begin w_addr = 3'd1; w_din = DIVISOR[15:8];   w_next = S_CFG_LCR;   end
      S_CFG_LCR:   begin w_addr = 3'd3; w_din = LCR_CFG;         w_next = S_CFG_FCR;   end
      S_CFG_FCR:   begin w_addr = 3'd2; w_din = FCR_CFG;         w_next = S_CFG_IER;   end
      S_CFG_IER:   begin w_addr = 3'd1; w_din = 8'h00;           w_next = S_WAIT_DATA; end
      S_WRITE_THR: begin w_addr = 3'd0; w_din = r_hold;          w_next = S_WAIT_DATA; end
      default:     begin w_addr = 3'd0; w_din = 8'h00;           w_next = S_IDLE;      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ph       <= 2'd0;
      r_hold     <= 8'h00;
      r_lsr      <= 8'h00;
      r_tx_ready <= 1'b0;
      r_cs       <= 1'b0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= 3'd0;
      r_din      <= 8'h00;
      r_cfg_done <= 1'b0;
      r_tx_count <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_CFG_DLAB;
          r_ph    <= 2'd0;
        end
        S_WAIT_DATA: begin
          if (r_tx_ready && tx_valid) begin
            r_hold     <= tx_data;
            r_tx_ready <= 1'b0;
            r_state    <= S_POLL_LSR;
            r_ph       <= 2'd0;
          end
        end
        // Four-edge read; the decision at R4 uses the copy captured at R3
        S_POLL_LSR: begin
          case (r_ph)
            2'd0: begin r_cs <= 1'b1; r_addr <= A_LSR; r_ph <= 2'd1; end
            2'd1: begin r_rd <= 1'b1; r_ph <= 2'd2; end
            2'd2: begin r_lsr <= uart_dout; r_ph <= 2'd3; end
            default: begin
              r_cs <= 1'b0;
              r_rd <= 1'b0;
              r_ph <= 2'd0;
              if (r_lsr[5]) r_state <= S_WRITE_THR;
            end
          endcase
        end
        default: begin
          case (r_ph)
            2'd0: begin r_cs <= 1'b1; r_addr <= w_addr; r_din <= w_din; r_ph <= 2'd1; end
            2'd1: begin r_wr <= 1'b1; r_ph <= 2'd2; end
            default: begin
              r_cs    <= 1'b0;
              r_wr    <= 1'b0;
              r_ph    <= 2'd0;
              r_state <= w_next;
              if (w_next == S_WAIT_DATA) r_tx_ready <= 1'b1;
              if (r_state == S_CFG_IER) r_cfg_done <= 1'b1;
              if (r_state == S_WRITE_THR) r_tx_count <= r_tx_count + 16'd1;
            end
          endcase
        end
      endcase
    end
  end

  assign tx_ready  = r_tx_ready;
  assign uart_cs   = r_cs;
  assign uart_wr   = r_wr;
  assign uart_rd   = r_rd;
  assign uart_addr = r_addr;
  assign uart_din  = r_din;
  assign cfg_done  = r_cfg_done;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: bus monitor plus an LSR model that can
// report "busy" for a programmable number of polls.
module tb_uart_tx_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        uart_cs;
  logic        uart_wr;
  logic        uart_rd;
  logic [2:0]  uart_addr;
  logic [7:0]  uart_din;
  logic [7:0]  uart_dout;
  logic        cfg_done;
  logic [15:0] tx_count;

  int          checks;
  int          failures;
  int          busy_polls;
  logic [7:0]  lsr_ok;
  int          rd_cnt;
  int          overlap;
  logic        prev_wr;
  logic        prev_rd;
  logic [10:0] wq[$];
  logic [10:0] cfg_exp[6];
  int          n;

  uart_tx_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_cs   (uart_cs),
    .uart_wr   (uart_wr),
    .uart_rd   (uart_rd),
    .uart_addr (uart_addr),
    .uart_din  (uart_din),
    .uart_dout (uart_dout),
    .cfg_done  (cfg_done),
    .tx_count  (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign uart_dout = (busy_polls > 0) ? 8'h00 : lsr_ok;

  always @(negedge clk) begin
    if (uart_wr && !prev_wr) wq.push_back({uart_addr, uart_din});
    if (uart_rd && !prev_rd) rd_cnt++;
    if (prev_rd && !uart_rd && busy_polls > 0) busy_polls--;
    if ((uart_wr && uart_rd) || ((uart_wr || uart_rd) && !uart_cs)) overlap++;
    prev_wr = uart_wr;
    prev_rd = uart_rd;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; busy_polls = 0; lsr_ok = 8'h60;
    rd_cnt = 0; overlap = 0; prev_wr = 1'b0; prev_rd = 1'b0;
    cfg_exp[0] = {3'd3, 8'h83}; cfg_exp[1] = {3'd0, 8'h11}; cfg_exp[2] = {3'd1, 8'h00};
    cfg_exp[3] = {3'd3, 8'h03}; cfg_exp[4] = {3'd2, 8'h00}; cfg_exp[5] = {3'd1, 8'h00};
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;

    // Reset state
    tick(2);
    chk("rst_cs", uart_cs, 0);
    chk("rst_wr", uart_wr, 0);
    chk("rst_rd", uart_rd, 0);
    chk("rst_addr", uart_addr, 0);
    chk("rst_din", uart_din, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_count", tx_count, 0);

    // Configuration, with tx_valid toggling activity that must be ignored
    rst = 1'b0; tx_valid = 1'b1; tx_data = 8'hEE;
    tick(18);
    chk("cfg_done_e18", cfg_done, 0);
    chk("ready_e18", tx_ready, 0);
    tx_valid = 1'b0;
    tick(1);
    chk("cfg_done_e19", cfg_done, 1);
    chk("ready_e19", tx_ready, 1);
    chk("cfg_nwrites", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("cfg_wr%0d", i), wq[i], cfg_exp[i]);
    chk("cfg_reads", rd_cnt, 0);

    // Single byte, LSR immediately ready
    wq.delete(); rd_cnt = 0; lsr_ok = 8'h60;
    tx_data = 8'h41; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0; tx_data = 8'hFF;
    chk("b41_ready_fall", tx_ready, 0);
    tick(5);
    chk("b41_wr_e5", uart_wr, 0);
    tick(1);
    chk("b41_wr_e6", uart_wr, 1);
    chk("b41_addr_e6", uart_addr, 0);
    chk("b41_din_e6", uart_din, 8'h41);
    chk("b41_ready_e6", tx_ready, 0);
    tick(1);
    chk("b41_ready_e7", tx_ready, 1);
    chk("b41_cs_e7", uart_cs, 0);
    chk("b41_count", tx_count, 1);
    chk("b41_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("b41_write", wq[0], {3'd0, 8'h41});
    chk("b41_reads", rd_cnt, 1);

    // LSR busy for three polls
    wq.delete(); rd_cnt = 0; busy_polls = 3; lsr_ok = 8'h20;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0; tx_data = 8'h00;
    n = 0;
    do begin tick(1); n++; end while (!tx_ready && n < 100);
    chk("b55_edges", n, 19);
    chk("b55_reads", rd_cnt, 4);
    chk("b55_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("b55_write", wq[0], {3'd0, 8'h55});
    chk("b55_count", tx_count, 2);

    // Back-to-back bytes, one accept every 8 clocks
    wq.delete(); rd_cnt = 0; tx_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tx_data = 8'(i);
      tick(1);
      chk($sformatf("bb%0d_ready_fall", i), tx_ready, 0);
      tx_data = 8'hA5;
      tick(6);
      chk($sformatf("bb%0d_ready_e6", i), tx_ready, 0);
      tick(1);
      chk($sformatf("bb%0d_ready_e7", i), tx_ready, 1);
    end
    tx_valid = 1'b0;
    chk("bb_nwrites", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk($sformatf("bb_write%0d", i), wq[i], {3'd0, 8'(i + 1)});
    chk("bb_count", tx_count, 6);

    // tx_count wrap
    force dut.r_tx_count = 16'hFFFF;
    tx_data = 8'h10; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(6);
    release dut.r_tx_count;
    chk("wrap_pre", tx_count, 16'hFFFF);
    tick(1);
    chk("wrap_post", tx_count, 16'h0000);
    chk("wrap_ready", tx_ready, 1);

    // Reset during W2 of a THR write
    tx_data = 8'h77; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(6);
    chk("abort_wr_before", uart_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", uart_cs, 0);
    chk("abort_wr", uart_wr, 0);
    chk("abort_count", tx_count, 0);
    tick(1);
    wq.delete(); rd_cnt = 0;
    rst = 1'b0;
    tick(19);
    chk("abort_cfg_done", cfg_done, 1);
    tick(20);
    chk("abort_nwrites", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("abort_cfg%0d", i), wq[i], cfg_exp[i]);
    chk("abort_reads", rd_cnt, 0);
    chk("abort_count_after", tx_count, 0);

    chk("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter DIVISOR, default 16'h0011: baud divisor written as DLL = DIVISOR[7:0], then DLM = DIVISOR[15:8].
REQ-002 Parameter LCR_CFG, default 8'h03: line control value written after the divisor (8N1, DLAB=0).
REQ-003 Parameter FCR_CFG, default 8'h00: FIFO control value.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tx_data  input  8  byte to transmit; sampled only on the accept edge.
REQ-007 tx_valid  input  1  tx_data offered.
REQ-008 tx_ready  output  1  block can accept a byte; registered.
REQ-009 uart_cs  output  1  16750 chip select.
REQ-010 uart_wr  output  1  16750 write strobe.
REQ-011 uart_rd  output  1  16750 read strobe.
REQ-012 uart_addr  output  3  16750 register address.
REQ-013 uart_din  output  8  write data to the 16750.
REQ-014 uart_dout  input  8  read data from the 16750.
REQ-015 cfg_done  output  1  configuration finished; stays high until reset.
REQ-016 tx_count  output  16  count of bytes written to THR; wraps 16'hFFFF -> 16'h0000.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Write access SHALL take exactly 3 edges:
- W1: cs=1, addr/din set, wr=0.
- W2: wr=1.
- W3: cs=0, wr=0.
- addr/din held stable from W1 through W3.
REQ-019 Read access SHALL take exactly 4 edges:
- R1: cs=1, addr set.
- R2: rd=1.
- R3: uart_dout captured into an internal LSR copy.
- R4: cs=0, rd=0, branch decision.
REQ-020 uart_wr and uart_rd SHALL never be high in the same cycle, nor while uart_cs=0.
REQ-021 States: IDLE, CFG_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER, WAIT_DATA, POLL_LSR, WRITE_THR.
REQ-022 IDLE SHALL last one edge, then go to CFG_DLAB.
REQ-023 Configuration sequence, one write per state, in this order:
- LCR (addr 3) = LCR_CFG | 8'h80
- DLL (addr 0) = DIVISOR[7:0]
- DLM (addr 1) = DIVISOR[15:8]
- LCR (addr 3) = LCR_CFG
- FCR (addr 2) = FCR_CFG
- IER (addr 1) = 8'h00
REQ-024 The edge completing the IER write SHALL enter WAIT_DATA and set cfg_done=1 and tx_ready=1, i.e. the 19th rising edge after rst deasserts.
REQ-025 tx_ready SHALL be 1 only in WAIT_DATA, including the cycle of a new accept (it falls on the accept edge).
REQ-026 Accept SHALL occur on an edge with tx_ready=1 and tx_valid=1: tx_data latched into a 1-byte holding register, state -> POLL_LSR. tx_valid without tx_ready SHALL be ignored.
REQ-027 POLL_LSR SHALL read addr 5. At R4:
- captured bit5 (THRE) = 1: go to WRITE_THR.
- otherwise: repeat POLL_LSR starting with the next edge as R1, unbounded.
REQ-028 WRITE_THR SHALL write the holding register to addr 0. At W3: tx_count increments, state -> WAIT_DATA, tx_ready=1.
REQ-029 Minimum per-byte timing from the accept edge: uart_wr high after edge 6; tx_ready high after edge 7; peak throughput one byte per 8 clocks.
REQ-030 tx_data changes after accept SHALL NOT affect the byte written.
REQ-031 No tx_valid activity SHALL affect the configuration states.

Reset
REQ-032 rst=1 SHALL immediately force:
- state=IDLE
- uart_cs=0, uart_wr=0, uart_rd=0
- uart_addr=0, uart_din=0
- tx_ready=0, cfg_done=0
- tx_count=0, holding register=0, LSR copy=0
REQ-033 rst asserted mid-access or mid-byte SHALL abort the access without completing any strobe. After release, the full configuration sequence SHALL restart and the held byte SHALL be discarded.

Verification
REQ-034 Release reset, default parameters -> writes observed in order (3,8'h83),(0,8'h11),(1,8'h00),(3,8'h03),(2,8'h00),(1,8'h00); cfg_done=1 after the 19th edge.
REQ-035 LSR model returns 8'h60; send 8'h41 -> write (0,8'h41) with uart_wr high after accept edge 6; tx_count=1; tx_ready high after edge 7.
REQ-036 LSR returns 8'h00 for 3 polls, then 8'h20; send 8'h55 -> exactly 4 LSR reads and one THR write of 8'h55; no strobe overlap.
REQ-037 Back-to-back tx_valid=1 with bytes 8'h01..8'h04, LSR=8'h20 -> THR writes 01,02,03,04, each accepted 8 clocks apart; tx_count=4; tx_data changed right after each accept has no effect.
REQ-038 Preload tx_count=16'hFFFF via 65535 bytes (or force) and send one byte -> tx_count=16'h0000.
REQ-039 Assert rst during W2 of a THR write -> uart_cs/uart_wr low immediately; after release, config replays from LCR=8'h83 and no THR write of the aborted byte occurs.
